// File: rtl/irq_sync_if.sv
// Request-line bundle between the interrupt synchroniser and its consumer.
// The consumer drives inputs through master; the synchroniser attaches as slave.
interface irq_sync_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] pending;
    logic             irq;

    modport master (
        output async_in, clear, mask,
        input  sync_out, edge_pulse, pending, irq
    );

    modport slave (
        input  async_in, clear, mask,
        output sync_out, edge_pulse, pending, irq
    );
endinterface

// File: rtl/irq_sync.sv
// Per-channel interrupt synchroniser: metastability chain, optional glitch filter,
// edge detection by MODE, and sticky pending flags ORed into a masked irq.
module irq_sync #(
    parameter int                   WIDTH  = 6,
    parameter int                   STAGES = 2,
    parameter int                   FILTER = 0,
    parameter logic [2*WIDTH-1:0]   MODE   = {WIDTH{2'b01}}
) (
    input  logic      clk,
    input  logic      rst_n,
    irq_sync_if.slave bus
);
    if (STAGES < 2) begin : gBadStages
        $error("irq_sync: STAGES must be at least 2");
    end

    logic [WIDTH-1:0] syncOutVec;
    logic [WIDTH-1:0] edgePulseVec;
    logic [WIDTH-1:0] pendingVec;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gChan
            localparam logic [1:0] CH_MODE = MODE[2*gi +: 2];

            logic [STAGES-1:0] chainReg;
            logic              chainLast;
            logic              syncOutBit;
            logic              syncDReg;
            logic              edgeBit;
            logic              pendingReg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chainReg <= '0;
                end else begin
                    chainReg <= {chainReg[STAGES-2:0], bus.async_in[gi]};
                end
            end

            assign chainLast = chainReg[STAGES-1];

            if (FILTER == 0) begin : gNoFilter
                assign syncOutBit = chainLast;
            end else begin : gFilter
                localparam int             CW       = $clog2(FILTER + 1);
                localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

                logic [CW-1:0] cntReg;
                logic          levelReg;

                // A level change is only accepted after FILTER consecutive
                // disagreeing samples; any agreement restarts the count.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cntReg   <= '0;
                        levelReg <= 1'b0;
                    end else if (chainLast != levelReg) begin
                        if (cntReg == CNT_LAST) begin
                            cntReg   <= '0;
                            levelReg <= chainLast;
                        end else begin
                            cntReg <= cntReg + 1'b1;
                        end
                    end else begin
                        cntReg <= '0;
                    end
                end

                assign syncOutBit = levelReg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    syncDReg <= 1'b0;
                end else begin
                    syncDReg <= syncOutBit;
                end
            end

            always_comb begin
                edgeBit = 1'b0;
                case (CH_MODE)
                    2'b01:   edgeBit = syncOutBit & ~syncDReg;
                    2'b10:   edgeBit = ~syncOutBit & syncDReg;
                    2'b11:   edgeBit = syncOutBit ^ syncDReg;
                    default: edgeBit = 1'b0;
                endcase
            end

            // Set has priority over clear so an event landing on a clear is kept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pendingReg <= 1'b0;
                end else if (CH_MODE == 2'b00) begin
                    pendingReg <= syncOutBit;
                end else if (edgeBit) begin
                    pendingReg <= 1'b1;
                end else if (bus.clear[gi]) begin
                    pendingReg <= 1'b0;
                end
            end

            assign syncOutVec[gi]   = syncOutBit;
            assign edgePulseVec[gi] = edgeBit;
            assign pendingVec[gi]   = pendingReg;
        end
    endgenerate

    assign bus.sync_out   = syncOutVec;
    assign bus.edge_pulse = edgePulseVec;
    assign bus.pending    = pendingVec;
    assign bus.irq        = |(pendingVec & bus.mask);
endmodule

// File: tb/tb_irq_sync.sv
// Directed bench for irq_sync with WIDTH=4, STAGES=2, FILTER=3 and
// channel modes rising/falling/both/level on ch0..ch3.
module tb_irq_sync;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irq_sync_if #(.WIDTH(4)) bus ();

    irq_sync #(
        .WIDTH (4),
        .STAGES(2),
        .FILTER(3),
        .MODE  (8'b00_11_10_01)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b1;
        bus.async_in = 4'b0000;
        bus.clear    = 4'b0000;
        bus.mask     = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sync_out", 32'(bus.sync_out), 32'h0);
        check("rst_edge", 32'(bus.edge_pulse), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        tick(2);
        rst_n = 1'b1;

        // ch0 rising: flips after edge 5, pending after edge 6
        bus.async_in = 4'b0001;
        tick(4);
        check("t1_sync_e4", 32'(bus.sync_out), 32'h0);
        tick(1);
        check("t1_sync_e5", 32'(bus.sync_out), 32'h1);
        check("t1_edge_e5", 32'(bus.edge_pulse), 32'h1);
        check("t1_pend_e5", 32'(bus.pending), 32'h0);
        check("t1_irq_e5", 32'(bus.irq), 32'h0);
        tick(1);
        check("t1_edge_e6", 32'(bus.edge_pulse), 32'h0);
        check("t1_pend_e6", 32'(bus.pending), 32'h1);
        check("t1_irq_e6", 32'(bus.irq), 32'h1);
        bus.clear = 4'b0001;
        tick(1);
        bus.clear = 4'b0000;
        check("t1_pend_clr", 32'(bus.pending), 32'h0);
        check("t1_irq_clr", 32'(bus.irq), 32'h0);

        // ch0 fall is not an event in rising mode; then clear collides with set
        bus.async_in = 4'b0000;
        tick(6);
        check("t2_pend_fall", 32'(bus.pending), 32'h0);
        check("t2_sync_fall", 32'(bus.sync_out), 32'h0);
        bus.async_in = 4'b0001;
        tick(5);
        check("t2_edge", 32'(bus.edge_pulse), 32'h1);
        bus.clear = 4'b0001;
        tick(1);
        bus.clear = 4'b0000;
        check("t2_set_wins", 32'(bus.pending), 32'h1);

        // ch1 falling: rise ignored, fall sets pending
        bus.async_in = 4'b0011;
        tick(6);
        check("t3_sync_rise", 32'(bus.sync_out), 32'h3);
        check("t3_pend_rise", 32'(bus.pending), 32'h1);
        bus.async_in = 4'b0001;
        tick(5);
        check("t3_edge_fall", 32'(bus.edge_pulse), 32'h2);
        tick(1);
        check("t3_pend_fall", 32'(bus.pending), 32'h3);

        // ch2 both: 2-cycle glitch is filtered out
        bus.async_in = 4'b0101;
        tick(2);
        bus.async_in = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t4_glitch_sync", 32'(bus.sync_out), 32'h1);
            check("t4_glitch_edge", 32'(bus.edge_pulse), 32'h0);
            check("t4_glitch_pend", 32'(bus.pending), 32'h3);
        end
        // 4-cycle pulse passes: one event at rise, one at fall
        bus.async_in = 4'b0101;
        tick(4);
        bus.async_in = 4'b0001;
        tick(1);
        check("t4_edge_rise", 32'(bus.edge_pulse), 32'h4);
        check("t4_sync_rise", 32'(bus.sync_out), 32'h5);
        tick(1);
        check("t4_pend_rise", 32'(bus.pending), 32'h7);
        bus.clear = 4'b0100;
        tick(1);
        bus.clear = 4'b0000;
        check("t4_pend_clr", 32'(bus.pending), 32'h3);
        tick(1);
        check("t4_edge_e8", 32'(bus.edge_pulse), 32'h0);
        tick(1);
        check("t4_sync_fall", 32'(bus.sync_out), 32'h1);
        check("t4_edge_fall", 32'(bus.edge_pulse), 32'h4);
        tick(1);
        check("t4_pend_fall", 32'(bus.pending), 32'h7);

        // ch3 level: pending follows sync_out one cycle later, clear ignored
        bus.async_in = 4'b1001;
        tick(4);
        check("t5_sync_e4", 32'(bus.sync_out), 32'h1);
        check("t5_pend_e4", 32'(bus.pending), 32'h7);
        tick(1);
        check("t5_sync_e5", 32'(bus.sync_out), 32'h9);
        check("t5_pend_e5", 32'(bus.pending), 32'h7);
        check("t5_edge_lvl", 32'(bus.edge_pulse), 32'h0);
        tick(1);
        check("t5_pend_e6", 32'(bus.pending), 32'hF);
        tick(2);
        bus.clear = 4'b1000;
        tick(1);
        bus.clear = 4'b0000;
        check("t5_pend_clr", 32'(bus.pending), 32'hF);
        tick(1);
        bus.async_in = 4'b0001;
        tick(4);
        check("t5_sync_f4", 32'(bus.sync_out), 32'h9);
        tick(1);
        check("t5_sync_f5", 32'(bus.sync_out), 32'h1);
        check("t5_pend_f5", 32'(bus.pending), 32'hF);
        tick(1);
        check("t5_pend_f6", 32'(bus.pending), 32'h7);

        // irq is combinational from pending & mask
        bus.clear = 4'b0010;
        tick(1);
        bus.clear = 4'b0000;
        check("t6_pend", 32'(bus.pending), 32'h5);
        bus.mask = 4'b0000;
        #1 check("t6_irq_m0", 32'(bus.irq), 32'h0);
        bus.mask = 4'b0100;
        #1 check("t6_irq_m4", 32'(bus.irq), 32'h1);
        bus.mask = 4'b1010;
        #1 check("t6_irq_mA", 32'(bus.irq), 32'h0);

        // fill pending, then reset mid-operation
        bus.mask     = 4'b1111;
        bus.async_in = 4'b1011;
        tick(6);
        check("t7_pend_d", 32'(bus.pending), 32'hD);
        check("t7_irq", 32'(bus.irq), 32'h1);
        bus.async_in = 4'b1001;
        tick(6);
        check("t7_pend_f", 32'(bus.pending), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_sync", 32'(bus.sync_out), 32'h0);
        check("t7_rst_edge", 32'(bus.edge_pulse), 32'h0);
        check("t7_rst_pend", 32'(bus.pending), 32'h0);
        check("t7_rst_irq", 32'(bus.irq), 32'h0);
        bus.async_in = 4'b0001;
        tick(2);
        check("t7_rst_hold", 32'(bus.pending), 32'h0);
        rst_n = 1'b1;
        tick(4);
        check("t7_edge_e4", 32'(bus.edge_pulse), 32'h0);
        check("t7_sync_e4", 32'(bus.sync_out), 32'h0);
        tick(1);
        check("t7_edge_e5", 32'(bus.edge_pulse), 32'h1);
        check("t7_sync_e5", 32'(bus.sync_out), 32'h1);
        check("t7_pend_e5", 32'(bus.pending), 32'h0);
        tick(1);
        check("t7_pend_e6", 32'(bus.pending), 32'h1);
        check("t7_edge_e6", 32'(bus.edge_pulse), 32'h0);
        check("t7_irq_e6", 32'(bus.irq), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
